// File: rtl/serial_parity_pkg.sv
// ============================================================================
// Module   : serial_parity_pkg
// Purpose  : Shared types and the parity helper for the serial parity
//            transmitter. Build option: SERIAL_PARITY_ODD_EN selects odd parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_parity_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int c_PAR_MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DADOS    = 2'd1,
        PARIDADE = 2'd2
    } state_t;

    // Callers zero-extend their word; the padding zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [c_PAR_MAX_W-1:0] word);
`ifdef SERIAL_PARITY_ODD_EN
        return ~^word;
`else
        return ^word;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_parity_tx.sv
// ============================================================================
// Module   : serial_parity_tx
// Purpose  : Valid/ready parallel word in, LSB-first serial frame out followed
//            by one parity bit. Build option: SERIAL_PARITY_ODD_EN (odd parity).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_tx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dado_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              Saida_serial,
    output logic              busy,
    output logic              frame_done
);

    localparam int               CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              r_state;
    logic [DATA_W-2:0]   r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_parity;
    logic                r_serial;
    logic                w_accept;

    // Bit 0 goes straight to the line on accept, so the shifter only holds bits 1..N-1.
    assign ready_out    = (r_state != DADOS);
    assign w_accept     = valid_in & ready_out;
    assign Saida_serial = r_serial;
    assign busy         = (r_state != IDLE);
    assign frame_done   = (r_state == PARIDADE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b0;
        end else begin
            case (r_state)
                DADOS: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_serial <= r_parity;
                        r_state  <= PARIDADE;
                    end else begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_shift  <= dado_in[DATA_W-1:1];
                        r_parity <= parity_bit(c_PAR_MAX_W'(dado_in));
                        r_cnt    <= '0;
                        r_serial <= dado_in[0];
                        r_state  <= DADOS;
                    end else begin
                        r_serial <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_tx.sv
// ============================================================================
// Module   : tb_serial_parity_tx
// Purpose  : Self-checking bench for serial_parity_tx with a line scoreboard
//            and a running-parity detector. Honours SERIAL_PARITY_ODD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_tx;

    localparam int DATA_W = 8;
`ifdef SERIAL_PARITY_ODD_EN
    localparam logic c_ODD = 1'b1;
`else
    localparam logic c_ODD = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] dado_in;
    logic              valid_in;
    logic              ready_out;
    logic              Saida_serial;
    logic              busy;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    serial_parity_tx #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dado_in      (dado_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .Saida_serial (Saida_serial),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line: front entry is the bit currently on the wire, the rest follow.
    logic q_line[$];
    logic det_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_line.delete();
        end else begin
            automatic logic accept = valid_in && (q_line.size() <= 1);
            automatic logic par    = (^dado_in) ^ c_ODD;
            if (q_line.size() > 0) void'(q_line.pop_front());
            if (accept) begin
                for (int i = 0; i < DATA_W; i++) q_line.push_back(dado_in[i]);
                q_line.push_back(par);
            end
        end
    end

    always @(negedge clk) begin
        automatic logic exp_busy = (q_line.size() > 0);
        automatic logic exp_line = exp_busy ? q_line[0] : 1'b0;
        automatic logic exp_done = (q_line.size() == 1);
        check("sb_line",       Saida_serial, exp_line);
        check("sb_busy",       busy,         exp_busy);
        check("sb_frame_done", frame_done,   exp_done);
        check("sb_ready",      ready_out,    q_line.size() <= 1);
        if (!reset) begin
            det_acc = 1'b0;
        end else if (exp_busy) begin
            det_acc = det_acc ^ Saida_serial;
            if (exp_done) begin
                check("detector_end", det_acc, c_ODD);
                det_acc = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word for one edge from an idle line; returns just after the accept edge.
    task automatic send(input logic [DATA_W-1:0] d);
        dado_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              par_even;
    } vec_t;

    vec_t vecs[6];

    initial begin
        det_acc  = 1'b0;
        reset    = 1'b0;
        valid_in = 1'b0;
        dado_in  = '0;
        #1;
        check("rst_line_preclk",  Saida_serial, 1'b0);
        check("rst_ready_preclk", ready_out,    1'b1);
        check("rst_busy_preclk",  busy,         1'b0);
        check("rst_done_preclk",  frame_done,   1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_line", Saida_serial, 1'b0);
        check("idle_ready", ready_out,   1'b1);

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'h55, 1'b0};
        vecs[5] = '{8'hFE, 1'b1};

        foreach (vecs[k]) begin
            send(vecs[k].data);
            check("bit0", Saida_serial, vecs[k].data[0]);
            for (int b = 1; b < DATA_W; b++) begin
                tick();
                check("data_bit", Saida_serial, vecs[k].data[b]);
                check("no_done_mid", frame_done, 1'b0);
            end
            tick();
            check("parity_bit", Saida_serial, vecs[k].par_even ^ c_ODD);
            check("frame_done", frame_done,   1'b1);
            tick();
            check("idle_after", Saida_serial, 1'b0);
            check("idle_busy",  busy,         1'b0);
        end

        // Back-to-back frames with valid_in held high
        dado_in  = 8'h01;
        valid_in = 1'b1;
        tick();
        dado_in = 8'hFF;
        repeat (DATA_W) tick();
        check("b2b_par1",   Saida_serial, 1'b1 ^ c_ODD);
        check("b2b_ready",  ready_out,    1'b1);
        tick();
        valid_in = 1'b0;
        check("b2b_bit0",   Saida_serial, 1'b1);
        check("b2b_done0",  frame_done,   1'b0);
        check("b2b_busy",   busy,         1'b1);
        repeat (DATA_W) tick();
        check("b2b_par2",   Saida_serial, 1'b0 ^ c_ODD);
        check("b2b_done2",  frame_done,   1'b1);
        tick();

        // Word offered mid-frame is ignored; reset at bit 4 abandons the frame
        send(8'h96);
        tick();
        tick();
        dado_in  = 8'h3C;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("ignore_bit3", Saida_serial, 1'b0);
        tick();
        check("pre_rst_bit4", Saida_serial, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_line",  Saida_serial, 1'b0);
        check("midrst_busy",  busy,         1'b0);
        check("midrst_done",  frame_done,   1'b0);
        check("midrst_ready", ready_out,    1'b1);
        tick();
        reset = 1'b1;
        tick();
        send(8'hA5);
        repeat (DATA_W) tick();
        check("post_rst_par",  Saida_serial, 1'b0 ^ c_ODD);
        check("post_rst_done", frame_done,   1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_parity_tx.md
Name: serial_parity_tx

Overview:
- Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on one serial line, then appends one parity bit.
- Transmit-side counterpart of the team's serial even-parity detector.
- After a complete frame, the running 1-count on the line is even, so a detector that was in PAR at frame start ends the frame in PAR.
- Sits between a parallel producer and the single-wire serial link.

Parameters:
- DATA_W, 8, number of data bits per frame (≥2).

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- dado_in  input  DATA_W  parallel word to transmit; sampled only on an accepted handshake.
- valid_in  input  1  producer has a word on dado_in.
- ready_out  output  1  transmitter can accept a word this cycle.
- Saida_serial  output  1  registered serial line; bit = 0 when idle.
- busy  output  1  frame in progress (DADOS or PARIDADE state).
- frame_done  output  1  one-cycle pulse, high during the cycle the parity bit is on the line.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, immediate, no clock needed):
  - state=IDLE, shift register=0, bit counter=0, parity register=0.
  - Saida_serial=0, busy=0, frame_done=0, ready_out=1.
- States: IDLE, DADOS, PARIDADE (enum, 2 bits).
- Handshake:
  - Word accepted on the rising edge where valid_in & ready_out.
  - ready_out is combinational: 1 in IDLE and in PARIDADE, 0 in DADOS.
  - valid_in while ready_out=0 is ignored; the word is not queued.
- Accept edge:
  - shift register ← dado_in.
  - parity register ← ^dado_in (even parity).
  - counter ← 0.
  - Saida_serial ← dado_in[0].
  - state ← DADOS.
- Latency: bit 0 appears on Saida_serial in the first cycle after the accept edge.
- DADOS:
  - Each edge shifts right: Saida_serial ← next bit, counter increments.
  - After bit DATA_W-1 has been on the line one cycle: Saida_serial ← parity register, state ← PARIDADE.
  - Exactly DATA_W cycles spent in DADOS.
- PARIDADE (one cycle): Saida_serial = parity, frame_done=1, busy=1.
  - If valid_in=1: accept a new word (back-to-back); next cycle carries its bit 0, state DADOS.
  - Else: state ← IDLE, Saida_serial ← 0.
- Frame length DATA_W+1 cycles; sustained throughput is one word per DATA_W+1 cycles with no idle gap.
- busy = (state != IDLE). frame_done = (state == PARIDADE).
- Changing dado_in after the accept edge has no effect on the current frame.
- Reset mid-frame: frame abandoned, line forced to 0 immediately, no frame_done pulse.
- Counter width is $clog2(DATA_W). The counter never wraps past DATA_W-1.

Optional Feature:
- SERIAL_PARITY_ODD_EN defined: parity register ← ~^dado_in, so the total 1-count per frame is odd.
- Undefined: even parity as specified above.
- Nothing else changes (timing and ports are identical).

Decomposition:
- Package serial_parity_pkg:
  - state enum type (IDLE, DADOS, PARIDADE).
  - localparam DATA_W_DEFAULT = 8.
  - function computing parity of a DATA_W word, honouring SERIAL_PARITY_ODD_EN.
- No sub-module needed: a single FSM + shift register + counter.
- The bench instantiates the existing serial even-parity detector on Saida_serial as the end-to-end checker.

Test Plan:
- Reset low for 2 cycles, then release → Saida_serial=0, ready_out=1, busy=0, frame_done=0, including before any clock edge.
- dado_in=8'hA5 accepted → line 1,0,1,0,0,1,0,1 then parity 0; frame_done high on cycle 9 only; detector ends PAR.
- dado_in=8'h07 → line 1,1,1,0,0,0,0,0 then parity 1; detector ends PAR; IDLE line 0 afterwards.
- Back-to-back: valid_in held high with 8'h01 then 8'hFF → frames of 9 cycles each with no gap (parity 1 then 0); ready_out high only in IDLE/PARIDADE cycles.
- Word 8'h3C offered mid-frame (DADOS) → ignored, current frame unchanged; reset pulsed low at bit 4 → line 0 at once, no frame_done, next word transmits cleanly.
- Build with SERIAL_PARITY_ODD_EN, send 8'hA5 → parity bit 1; send 8'h00 → parity bit 1.
